// File: rtl/unidad_control_multiciclo.sv
// -----------------------------------------------------------------------------
// unidad_control_multiciclo
//
// Control unit for a multicycle MIPS datapath. It is a Moore FSM that walks the
// shared memory/ALU/register-file/PC datapath through the FETCH, DECODE,
// EXECUTE, MEMORY and WRITEBACK steps. Memory accesses wait on MEM_READY, and
// an unsupported opcode parks the FSM in a sticky TRAP state until reset.
//
// Build option:
//   UCM_JUMP_EN - when defined, opcode 0x02 (j) is executed through the JUMP
//                 state. When undefined, 0x02 traps like any other unsupported
//                 opcode, and encoding 11 is treated as an unused encoding.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   OPCODE[5:0]    IR[31:26]; only looked at in DECODE
//   MEM_READY      memory completes the current access this cycle
//   PC_WRITE, PC_WRITE_COND, IOR_D, MEM_READ, MEM_WRITE, IR_WRITE,
//   MEM_TO_REG, REG_WRITE, REG_DST, ALU_SRC_A   datapath strobes / selects
//   ALU_SRC_B[1:0] 00 regB, 01 const 4, 10 sext imm, 11 sext imm<<2
//   ALU_OP[1:0]    00 add, 01 sub, 10 decoded from funct
//   PC_SOURCE[1:0] 00 ALU result, 01 ALUOut, 10 jump target
//   DONE           one-cycle pulse in the last cycle of each instruction
//   ILLEGAL        high while in TRAP
//   STATE[3:0]     current state encoding (debug)
// -----------------------------------------------------------------------------
module unidad_control_multiciclo (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] OPCODE,
  input  logic       MEM_READY,
  output logic       PC_WRITE,
  output logic       PC_WRITE_COND,
  output logic       IOR_D,
  output logic       MEM_READ,
  output logic       MEM_WRITE,
  output logic       IR_WRITE,
  output logic       MEM_TO_REG,
  output logic       REG_WRITE,
  output logic       REG_DST,
  output logic       ALU_SRC_A,
  output logic [1:0] ALU_SRC_B,
  output logic [1:0] ALU_OP,
  output logic [1:0] PC_SOURCE,
  output logic       DONE,
  output logic       ILLEGAL,
  output logic [3:0] STATE
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADR   = 4'd2,
    S_MEM_RD    = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WR    = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BEQ       = 4'd8,
    S_ADDI_EXEC = 4'd9,
    S_ADDI_WB   = 4'd10,
    S_JUMP      = 4'd11,
    S_TRAP      = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  state_e state_q, state_d;
  // OPCODE is only valid in DECODE, so remember whether a memory op is a store
  // for the MEM_ADR branch one cycle later.
  logic   is_sw_q, is_sw_d;

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (!rst_n) begin
      state_q <= S_FETCH;
      is_sw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      is_sw_q <= is_sw_d;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    state_d = S_FETCH;
    is_sw_d = is_sw_q;
    unique case (state_q)
      S_FETCH:     state_d = MEM_READY ? S_DECODE : S_FETCH;
      S_DECODE: begin
        is_sw_d = (OPCODE == OP_SW);
        case (OPCODE)
          OP_RTYPE:      state_d = S_R_EXEC;
          OP_LW, OP_SW:  state_d = S_MEM_ADR;
          OP_BEQ:        state_d = S_BEQ;
          OP_ADDI:       state_d = S_ADDI_EXEC;
`ifdef UCM_JUMP_EN
          OP_J:          state_d = S_JUMP;
`endif
          default:       state_d = S_TRAP;
        endcase
      end
      S_MEM_ADR:   state_d = is_sw_q ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:    state_d = MEM_READY ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:    state_d = MEM_READY ? S_FETCH : S_MEM_WR;
      S_R_EXEC:    state_d = S_R_WB;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_TRAP:      state_d = S_TRAP;
      // MEM_WB, R_WB, ADDI_WB, BEQ, JUMP and unused encodings return to FETCH.
      default:     state_d = S_FETCH;
    endcase
  end

  // Output logic: Moore outputs, with MEM_READY gating in the wait states.
  // Everything reads 0 while reset is held so no write lands mid-reset.
  always_comb begin
    PC_WRITE      = 1'b0;
    PC_WRITE_COND = 1'b0;
    IOR_D         = 1'b0;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    IR_WRITE      = 1'b0;
    MEM_TO_REG    = 1'b0;
    REG_WRITE     = 1'b0;
    REG_DST       = 1'b0;
    ALU_SRC_A     = 1'b0;
    ALU_SRC_B     = 2'b00;
    ALU_OP        = 2'b00;
    PC_SOURCE     = 2'b00;
    DONE          = 1'b0;
    ILLEGAL       = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          MEM_READ  = 1'b1;
          ALU_SRC_B = 2'b01;
          IR_WRITE  = MEM_READY;
          PC_WRITE  = MEM_READY;
        end
        S_DECODE:    ALU_SRC_B = 2'b11;
        S_MEM_ADR: begin
          ALU_SRC_A = 1'b1;
          ALU_SRC_B = 2'b10;
        end
        S_MEM_RD: begin
          MEM_READ = 1'b1;
          IOR_D    = 1'b1;
        end
        S_MEM_WB: begin
          REG_WRITE  = 1'b1;
          MEM_TO_REG = 1'b1;
          DONE       = 1'b1;
        end
        S_MEM_WR: begin
          MEM_WRITE = 1'b1;
          IOR_D     = 1'b1;
          DONE      = MEM_READY;
        end
        S_R_EXEC: begin
          ALU_SRC_A = 1'b1;
          ALU_OP    = 2'b10;
        end
        S_R_WB: begin
          REG_WRITE = 1'b1;
          REG_DST   = 1'b1;
          DONE      = 1'b1;
        end
        S_BEQ: begin
          ALU_SRC_A     = 1'b1;
          ALU_OP        = 2'b01;
          PC_WRITE_COND = 1'b1;
          PC_SOURCE     = 2'b01;
          DONE          = 1'b1;
        end
        S_ADDI_EXEC: begin
          ALU_SRC_A = 1'b1;
          ALU_SRC_B = 2'b10;
        end
        S_ADDI_WB: begin
          REG_WRITE = 1'b1;
          DONE      = 1'b1;
        end
`ifdef UCM_JUMP_EN
        S_JUMP: begin
          PC_WRITE  = 1'b1;
          PC_SOURCE = 2'b10;
          DONE      = 1'b1;
        end
`endif
        S_TRAP:      ILLEGAL = 1'b1;
        default: ;
      endcase
    end
  end

  assign STATE = state_q;

endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// -----------------------------------------------------------------------------
// Testbench for unidad_control_multiciclo. Each table record is one clock
// cycle: inputs are driven on the falling edge, and STATE plus a packed output
// word are checked 1 ns later, before the next rising edge. Hand-written
// sequences then cover the sticky TRAP, reset out of TRAP, and opcode 0x02.
//
// Packed output word, MSB first:
//   [17] PC_WRITE  [16] PC_WRITE_COND  [15] IOR_D  [14] MEM_READ
//   [13] MEM_WRITE [12] IR_WRITE [11] MEM_TO_REG [10] REG_WRITE [9] REG_DST
//   [8] ALU_SRC_A  [7:6] ALU_SRC_B  [5:4] ALU_OP  [3:2] PC_SOURCE
//   [1] DONE  [0] ILLEGAL
// -----------------------------------------------------------------------------
module tb_unidad_control_multiciclo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, ior_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_write, reg_dst, alu_src_a, done, illegal;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  unidad_control_multiciclo dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .OPCODE        (opcode),
    .MEM_READY     (mem_ready),
    .PC_WRITE      (pc_write),
    .PC_WRITE_COND (pc_write_cond),
    .IOR_D         (ior_d),
    .MEM_READ      (mem_read),
    .MEM_WRITE     (mem_write),
    .IR_WRITE      (ir_write),
    .MEM_TO_REG    (mem_to_reg),
    .REG_WRITE     (reg_write),
    .REG_DST       (reg_dst),
    .ALU_SRC_A     (alu_src_a),
    .ALU_SRC_B     (alu_src_b),
    .ALU_OP        (alu_op),
    .PC_SOURCE     (pc_source),
    .DONE          (done),
    .ILLEGAL       (illegal),
    .STATE         (state)
  );

  always #5 clk = ~clk;

  // Expected output words, written by hand from the per-state output list.
  //                                   PW PWC IORD MR MW IRW M2R RW RD ASA ASB  AOP PCS D IL
  localparam logic [17:0] O_ZERO    = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] O_FETCH_R = 18'b1_0_0_1_0_1_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] O_FETCH_W = 18'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] O_DECODE  = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
  localparam logic [17:0] O_MEM_ADR = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [17:0] O_MEM_RD  = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] O_MEM_WB  = 18'b0_0_0_0_0_0_1_1_0_0_00_00_00_1_0;
  localparam logic [17:0] O_MEM_WRW = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] O_MEM_WRD = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_1_0;
  localparam logic [17:0] O_R_EXEC  = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
  localparam logic [17:0] O_R_WB    = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_1_0;
  localparam logic [17:0] O_BEQ     = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_1_0;
  localparam logic [17:0] O_ADDI_EX = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [17:0] O_ADDI_WB = 18'b0_0_0_0_0_0_0_1_0_0_00_00_00_1_0;
  localparam logic [17:0] O_JUMP    = 18'b1_0_0_0_0_0_0_0_0_0_00_00_10_1_0;
  localparam logic [17:0] O_TRAP    = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_1;

  typedef struct {
    logic        rst_n;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic [3:0]  exp_state;
    logic [17:0] exp_out;
  } vec_t;

  int n_vec  = 0;
  int n_fail = 0;

  function automatic logic [17:0] out_word();
    return {pc_write, pc_write_cond, ior_d, mem_read, mem_write, ir_write,
            mem_to_reg, reg_write, reg_dst, alu_src_a, alu_src_b, alu_op,
            pc_source, done, illegal};
  endfunction

  task automatic check(input string name, input logic [17:0] got,
                       input logic [17:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, got, exp);
    end
  endtask

  // Drive one cycle on the falling edge, check, leave time for the rising edge.
  task automatic cycle(input string name, input logic r, input logic [5:0] op,
                       input logic rdy, input logic [3:0] st,
                       input logic [17:0] o);
    @(negedge clk);
    rst_n     = r;
    opcode    = op;
    mem_ready = rdy;
    #1;
    check({name, " state"}, {14'd0, state}, {14'd0, st});
    check({name, " outputs"}, out_word(), o);
  endtask

  vec_t vecs[$];

  initial begin
    vecs = '{
      // reset held: outputs forced to 0 even with MEM_READY high
      '{1'b0, 6'h00, 1'b1, 4'd0,  O_ZERO},
      // R-type: 0,1,6,7
      '{1'b1, 6'h15, 1'b1, 4'd0,  O_FETCH_R},
      '{1'b1, 6'h00, 1'b1, 4'd1,  O_DECODE},
      '{1'b1, 6'h3F, 1'b1, 4'd6,  O_R_EXEC},
      '{1'b1, 6'h3F, 1'b1, 4'd7,  O_R_WB},
      // lw with one FETCH wait and two MEM_RD waits; opcode changes after DECODE
      '{1'b1, 6'h00, 1'b0, 4'd0,  O_FETCH_W},
      '{1'b1, 6'h00, 1'b1, 4'd0,  O_FETCH_R},
      '{1'b1, 6'h23, 1'b1, 4'd1,  O_DECODE},
      '{1'b1, 6'h2B, 1'b1, 4'd2,  O_MEM_ADR},
      '{1'b1, 6'h2B, 1'b0, 4'd3,  O_MEM_RD},
      '{1'b1, 6'h2B, 1'b0, 4'd3,  O_MEM_RD},
      '{1'b1, 6'h2B, 1'b1, 4'd3,  O_MEM_RD},
      '{1'b1, 6'h2B, 1'b1, 4'd4,  O_MEM_WB},
      // sw with one MEM_WR wait; DONE only with MEM_READY
      '{1'b1, 6'h00, 1'b1, 4'd0,  O_FETCH_R},
      '{1'b1, 6'h2B, 1'b1, 4'd1,  O_DECODE},
      '{1'b1, 6'h23, 1'b1, 4'd2,  O_MEM_ADR},
      '{1'b1, 6'h23, 1'b0, 4'd5,  O_MEM_WRW},
      '{1'b1, 6'h23, 1'b1, 4'd5,  O_MEM_WRD},
      // beq: 0,1,8
      '{1'b1, 6'h00, 1'b1, 4'd0,  O_FETCH_R},
      '{1'b1, 6'h04, 1'b1, 4'd1,  O_DECODE},
      '{1'b1, 6'h00, 1'b1, 4'd8,  O_BEQ},
      // addi: 0,1,9,10
      '{1'b1, 6'h00, 1'b1, 4'd0,  O_FETCH_R},
      '{1'b1, 6'h08, 1'b1, 4'd1,  O_DECODE},
      '{1'b1, 6'h00, 1'b1, 4'd9,  O_ADDI_EX},
      '{1'b1, 6'h00, 1'b1, 4'd10, O_ADDI_WB},
      // reset mid R-type: R_EXEC outputs forced 0, then back to FETCH
      '{1'b1, 6'h00, 1'b1, 4'd0,  O_FETCH_R},
      '{1'b1, 6'h00, 1'b1, 4'd1,  O_DECODE},
      '{1'b0, 6'h00, 1'b1, 4'd6,  O_ZERO},
      '{1'b1, 6'h00, 1'b1, 4'd0,  O_FETCH_R}
    };

    rst_n     = 1'b0;
    opcode    = 6'h00;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++)
      cycle($sformatf("vec%0d", i), vecs[i].rst_n, vecs[i].opcode,
            vecs[i].mem_ready, vecs[i].exp_state, vecs[i].exp_out);

    // Illegal opcode: sticky TRAP regardless of inputs
    cycle("trap_decode", 1'b1, 6'h3F, 1'b1, 4'd1, O_DECODE);
    for (int i = 0; i < 12; i++)
      cycle($sformatf("trap_hold%0d", i), 1'b1, 6'(i), 1'(i % 2), 4'd12, O_TRAP);
    // One reset edge leaves TRAP; ILLEGAL is masked while reset is low
    cycle("trap_rst", 1'b0, 6'h00, 1'b0, 4'd12, O_ZERO);
    cycle("trap_exit", 1'b1, 6'h00, 1'b0, 4'd0, O_FETCH_W);

    // Opcode 0x02
    cycle("j_fetch", 1'b1, 6'h00, 1'b1, 4'd0, O_FETCH_R);
    cycle("j_decode", 1'b1, 6'h02, 1'b1, 4'd1, O_DECODE);
`ifdef UCM_JUMP_EN
    cycle("j_exec", 1'b1, 6'h00, 1'b1, 4'd11, O_JUMP);
    cycle("j_back", 1'b1, 6'h00, 1'b1, 4'd0, O_FETCH_R);
`else
    cycle("j_trap", 1'b1, 6'h00, 1'b1, 4'd12, O_TRAP);
    cycle("j_trap_hold", 1'b1, 6'h00, 1'b1, 4'd12, O_TRAP);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
